// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Arbitrates a single-port, synchronous-read video RAM between a
//            display fetch engine and a CPU port.
//            - The display port always wins. Its read data appears exactly
//              2 cycles after the strobe.
//            - CPU accesses wait in PEND until they find a free RAM cycle.
//            - A sticky flag reports when the CPU has been blocked for 15
//              cycles.
// Option   : `define VRAM_ARB_WRITE_BUFFER_EN adds a one-entry posted write
//            buffer.
//            - An idle-time write with the buffer empty is acked after
//              1 cycle.
//            - The buffer drains in the first cycle with no display strobe.
//            - Reads, and writes that find the buffer full, wait until the
//              buffer is empty.
// Ports    : i_clk, i_rst (async, active-high)
//            i_disp_req/i_disp_addr     -> o_disp_valid/o_disp_data
//            i_cpu_req/we/addr/wdata    -> o_cpu_ack/o_cpu_rdata
//            o_ram_addr/we/wdata, i_ram_rdata  (RAM, 1-cycle read latency)
//            o_cpu_starved              sticky starvation flag
// Revision : 1.0  initial release
// ============================================================================
module vram_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_disp_req,
    input  logic [10:0] i_disp_addr,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [10:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [10:0] o_ram_addr,
    output logic        o_ram_we,
    output logic [7:0]  o_ram_wdata,
    input  logic [7:0]  i_ram_rdata,
    output logic        o_cpu_starved
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_MAX = 4'd15;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_req_we;
    logic [10:0] r_req_addr;
    logic [7:0]  r_req_wdata;
    logic        r_disp_p1;
    logic [3:0]  r_wait_cnt;

    logic        w_buf_valid;
    logic [10:0] w_buf_addr;
    logic [7:0]  w_buf_data;
    logic        w_buf_accept;  // IDLE write that can be posted immediately
    logic        w_drain;
    logic        w_blocked;
    logic        w_issue;

`ifdef VRAM_ARB_WRITE_BUFFER_EN
    logic        r_buf_valid;
    logic [10:0] r_buf_addr;
    logic [7:0]  r_buf_data;

    assign w_buf_valid  = r_buf_valid;
    assign w_buf_addr   = r_buf_addr;
    assign w_buf_data   = r_buf_data;
    assign w_buf_accept = i_cpu_we & ~r_buf_valid;
    assign w_drain      = r_buf_valid & ~i_disp_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else if (r_state == ST_IDLE && i_cpu_req && w_buf_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= i_cpu_addr;
            r_buf_data  <= i_cpu_wdata;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end
`else
    assign w_buf_valid  = 1'b0;
    assign w_buf_addr   = '0;
    assign w_buf_data   = '0;
    assign w_buf_accept = 1'b0;
    assign w_drain      = 1'b0;
`endif

    // A pending CPU access also yields to an undrained buffer entry.
    // This keeps read-after-write ordering coherent.
    assign w_blocked = i_disp_req | w_buf_valid;
    assign w_issue   = (r_state == ST_PEND) & ~w_blocked;
    assign o_cpu_ack = (r_state == ST_ACK);

    // RAM port mux: display > buffer drain > pending CPU access.
    always_comb begin
        o_ram_addr  = r_req_addr;
        o_ram_wdata = r_req_wdata;
        o_ram_we    = 1'b0;
        if (i_disp_req) begin
            o_ram_addr = i_disp_addr;
        end else if (w_drain) begin
            o_ram_addr  = w_buf_addr;
            o_ram_wdata = w_buf_data;
            o_ram_we    = 1'b1;
        end else if (w_issue) begin
            o_ram_we = r_req_we;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_req) begin
                    w_state_next = w_buf_accept ? ST_ACK : ST_PEND;
                end
            end
            ST_PEND: begin
                if (!w_blocked) begin
                    w_state_next = r_req_we ? ST_ACK : ST_RDWAIT;
                end
            end
            ST_RDWAIT: w_state_next = ST_ACK;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_req_we      <= 1'b0;
            r_req_addr    <= '0;
            r_req_wdata   <= '0;
            o_cpu_rdata   <= '0;
            r_wait_cnt    <= '0;
            o_cpu_starved <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && i_cpu_req) begin
                r_req_we    <= i_cpu_we;
                r_req_addr  <= i_cpu_addr;
                r_req_wdata <= i_cpu_wdata;
            end
            if (r_state == ST_RDWAIT) begin
                o_cpu_rdata <= i_ram_rdata;
            end
            if (r_state == ST_ACK) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_PEND && w_blocked) begin
                if (r_wait_cnt != C_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                // Flag in the same edge the counter reaches its ceiling.
                if (r_wait_cnt >= C_WAIT_MAX - 4'd1) begin
                    o_cpu_starved <= 1'b1;
                end
            end
        end
    end

    // Display return path: the address is presented in the strobe cycle.
    // The RAM answers one cycle later. The answer is registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp_p1    <= 1'b0;
            o_disp_valid <= 1'b0;
            o_disp_data  <= '0;
        end else begin
            r_disp_p1    <= i_disp_req;
            o_disp_valid <= r_disp_p1;
            if (r_disp_p1) begin
                o_disp_data <= i_ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter.
//            - A RAM model and a reference memory predict display and CPU
//              read data.
//            - The monitor pops the expected values as outputs appear.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

`ifdef VRAM_ARB_WRITE_BUFFER_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = 2;
`endif
    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [10:0] disp_addr = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        cpu_starved;

    vram_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_valid(disp_valid), .o_disp_data(disp_data),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_cpu_starved(cpu_starved)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] init_pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // RAM model (synchronous read, old data on read-during-write)
    logic [7:0]  mem [0:2047];
    logic        mem_init = 1'b1;
    int          wr_cnt = 0;
    logic [10:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_pat(i);
        end else begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt       = wr_cnt + 1;
                last_wr_addr = ram_addr;
                last_wr_data = ram_wdata;
            end
        end
    end

    // Reference model: memory contents as the CPU sees them in program order.
    logic [7:0] ref_mem [0:2047];
    logic [7:0] last_rdata = 8'h00;

    typedef struct {
        int         due;
        logic [7:0] data;
    } dexp_t;
    dexp_t      dq[$];
    logic [7:0] cq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    dexp_t      mon_d;
    logic [7:0] mon_c;
    always @(negedge clk) begin
        if (!rst) begin
            if (disp_req) begin
                chk("disp_prio_addr", 32'(ram_addr), 32'(disp_addr));
                chk("disp_prio_we", 32'(ram_we), 32'd0);
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                mon_d = dq.pop_front();
                chk("disp_valid", 32'(disp_valid), 32'd1);
                chk("disp_data", 32'(disp_data), 32'(mon_d.data));
            end else if (disp_valid) begin
                chk("disp_spurious", 32'(disp_valid), 32'd0);
            end
            if (cpu_ack) begin
                if (cq.size() == 0) begin
                    chk("cpu_ack_spurious", 32'(cpu_ack), 32'd0);
                end else begin
                    mon_c = cq.pop_front();
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_c));
                end
            end
        end
    end

    // All drivers are called #1 after a rising edge.
    task automatic disp_drive(input logic req, input logic [10:0] a);
        dexp_t e;
        disp_req  = req;
        disp_addr = a;
        if (req) begin
            e.due  = cyc + 2;
            e.data = ref_mem[a];
            dq.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [10:0] a, input logic [7:0] d,
                          output int lat, output int ack_cyc);
        int start;
        bit got;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        start     = cyc;
        if (we) begin
            ref_mem[a] = d;
            cq.push_back(last_rdata);
        end else begin
            last_rdata = ref_mem[a];
            cq.push_back(last_rdata);
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        chk("cpu_ack_timeout", 32'(got), 32'd1);
        lat     = got ? cyc - start : -1;
        ack_cyc = cyc;
        step();
        cpu_req = 1'b0;
    endtask

    int         lat, ack_c, wc0, last_disp;
    logic [7:0] old;

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_pat(i);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        step();

        // Reset state
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_starved", 32'(cpu_starved), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        rst = 1'b0;

        // Unloaded write then read of 0x3FF
        wc0 = wr_cnt;
        cpu_op(1'b1, 11'h3FF, 8'hA5, lat, ack_c);
        chk("wr_latency", 32'(lat), 32'(WR_LAT));
        repeat (3) step();
        chk("wr_count", 32'(wr_cnt - wc0), 32'd1);
        chk("wr_addr", 32'(last_wr_addr), 32'h3FF);
        chk("wr_data", 32'(last_wr_data), 32'hA5);
        cpu_op(1'b0, 11'h3FF, 8'h00, lat, ack_c);
        chk("rd_latency", 32'(lat), 32'(RD_LAT));
        chk("starved_clear", 32'(cpu_starved), 32'd0);

        // 20 cycles of continuous display traffic against a pending read
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    disp_drive(1'b1, 11'h400 + 11'(i));
                    last_disp = cyc;
                    step();
                end
                disp_drive(1'b0, 11'h0);
            end
            cpu_op(1'b0, 11'h3FF, 8'h00, lat, ack_c);
        join
        chk("ack_after_disp", 32'(ack_c > last_disp), 32'd1);
        chk("starved_set", 32'(cpu_starved), 32'd1);
        repeat (3) step();

        // Display strobe lands in the cycle the CPU write would issue
        old = ref_mem[11'h010];
        fork
            begin
                dexp_t e;
                step();
                disp_req  = 1'b1;
                disp_addr = 11'h010;
                e.due  = cyc + 2;
                e.data = old;
                dq.push_back(e);
                step();
                disp_req = 1'b0;
            end
            cpu_op(1'b1, 11'h010, 8'hC3, lat, ack_c);
        join
        chk("wr_blocked_latency", 32'(lat), 32'(WR_LAT == 1 ? 1 : 3));
        cpu_op(1'b0, 11'h010, 8'h00, lat, ack_c);
        repeat (3) step();

        // Reset while the CPU read sits in RDWAIT
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h3FF;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
        chk("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_mid_starved", 32'(cpu_starved), 32'd0);
        chk("rst_mid_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
        cpu_req = 1'b0;
        last_rdata = 8'h00;
        repeat (2) step();
        rst = 1'b0;
        cpu_op(1'b0, 11'h3FF, 8'h00, lat, ack_c);
        chk("post_rst_rd_latency", 32'(lat), 32'(RD_LAT));

        // Write then immediate read under display load
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    disp_drive(($urandom_range(0, 99) < 70), 11'h400 + 11'($urandom_range(0, 1023)));
                    step();
                end
                disp_drive(1'b0, 11'h0);
            end
            begin
                cpu_op(1'b1, 11'h020, 8'h5A, lat, ack_c);
                cpu_op(1'b0, 11'h020, 8'h00, lat, ack_c);
            end
        join
        repeat (3) step();

        // Randomized mixed traffic
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    disp_drive(($urandom_range(0, 99) < 40), 11'h400 + 11'($urandom_range(0, 1023)));
                    step();
                end
                disp_drive(1'b0, 11'h0);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    cpu_op(1'($urandom_range(0, 1)), 11'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), lat, ack_c);
                    if ($urandom_range(0, 3) == 0) step();
                end
            end
        join
        repeat (5) step();
        chk("disp_queue_empty", 32'(dq.size()), 32'd0);
        chk("cpu_queue_empty", 32'(cq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
